// File: rtl/sort_pkg.sv
// Shared sizing, one-hot FSM encoding and small helpers for the sorter host controller.
// Pure declarations; no latency or backpressure of its own.
package sort_pkg;

   localparam int N_MAX = 30;
   localparam int DW    = 7;
   localparam int WW    = 5;
   localparam int SCW   = 10;

   typedef enum logic [4:0] {
      LOAD  = 5'b00001,
      START = 5'b00010,
      WAIT  = 5'b00100,
      DRAIN = 5'b01000,
      ACK   = 5'b10000
   } state_t;

   function automatic logic [SCW-1:0] sat_inc(input logic [SCW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sort_host_ctrl_if.sv
// Host-side bundle: input element stream, sorted output stream and the sorter handshake.
// master = controller view, slave = datapath/sorter view; flow control is valid/ready on both streams.
interface sort_host_ctrl_if;
   import sort_pkg::*;

   logic                in_valid;
   logic [DW-1:0]       in_data;
   logic                in_last;
   logic                in_ready;

   logic                out_valid;
   logic [DW-1:0]       out_data;
   logic                out_last;
   logic                out_ready;

   logic [WW-1:0]       width;
   logic                Start;
   logic                Ack;
   logic [N_MAX*DW-1:0] Ain;
   logic [N_MAX*DW-1:0] Aout;
   logic                Done;

   modport master (
      input  in_valid, in_data, in_last, out_ready, Aout, Done,
      output in_ready, out_valid, out_data, out_last, width, Start, Ack, Ain
   );

   modport slave (
      output in_valid, in_data, in_last, out_ready, Aout, Done,
      input  in_ready, out_valid, out_data, out_last, width, Start, Ack, Ain
   );

endinterface

// File: rtl/sort_frame_buf.sv
// N x W register array with indexed write, parallel load, indexed read and packed-bus read.
// Writes land on the next edge; both reads are combinational; no backpressure.
module sort_frame_buf
   import sort_pkg::*;
#(
   parameter int N  = N_MAX,
   parameter int W  = DW,
   parameter int IW = WW
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic           clr,
   input  logic           wr_en,
   input  logic [IW-1:0]  wr_idx,
   input  logic [W-1:0]   wr_dat,
   input  logic           ld_en,
   input  logic [N*W-1:0] ld_dat,
   input  logic [IW-1:0]  rd_idx,
   output logic [W-1:0]   rd_dat,
   output logic [N*W-1:0] bus_dat
);

   logic [W-1:0] mem [N];

   always_ff @(posedge Clk) begin
      if (Reset || clr) begin
         for (int i = 0; i < N; i++) mem[i] <= '0;
      end else if (ld_en) begin
         for (int i = 0; i < N; i++) mem[i] <= ld_dat[i*W +: W];
      end else if (wr_en && (wr_idx < IW'(N))) begin
         mem[wr_idx] <= wr_dat;
      end
   end

   always_comb begin
      bus_dat = '0;
      for (int i = 0; i < N; i++) bus_dat[i*W +: W] = mem[i];
   end

   assign rd_dat = (rd_idx < IW'(N)) ? mem[rd_idx] : '0;

endmodule

// File: rtl/sort_host_ctrl.sv
// Sorter initiator: packs a frame into Ain, pulses Start, waits for Done, streams the sorted result, then acks.
// in_ready only in LOAD; output beats advance on out_valid&out_ready and hold while stalled.
module sort_host_ctrl
   import sort_pkg::*;
(
   input  logic                  Clk,
   input  logic                  Reset,
   sort_host_ctrl_if.master      bus,
   output logic [SCW-1:0]        sort_cycles
);

   state_t              state_q, state_d;
   logic [WW-1:0]       cnt_q;
   logic [WW-1:0]       width_q;
   logic [WW-1:0]       idx_q;
   logic [SCW-1:0]      sort_cycles_q;

   logic                in_acc;
   logic                frame_close;
   logic                out_acc;
   logic                out_end;
   logic                in_clr;
   logic                res_ld;
   logic [DW-1:0]       res_dat;
   logic [DW-1:0]       unused_in_rd;
   logic [N_MAX*DW-1:0] unused_res_bus;

   assign in_acc      = bus.in_valid && (state_q == LOAD);
   // A frame closes on in_last or on the slot that fills the array, whichever comes first.
   assign frame_close = in_acc && (bus.in_last || (cnt_q == WW'(N_MAX - 1)));
   assign out_end     = (idx_q == width_q - 1'b1);
   assign out_acc     = (state_q == DRAIN) && bus.out_ready;
   assign in_clr      = (state_q == ACK) && !bus.Done;
   assign res_ld      = (state_q == WAIT) && bus.Done;

   always_ff @(posedge Clk) begin
      if (Reset) state_q <= LOAD;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      bus.in_ready  = 1'b0;
      bus.Start     = 1'b0;
      bus.Ack       = 1'b0;
      bus.out_valid = 1'b0;
      case (state_q)
         LOAD: begin
            bus.in_ready = 1'b1;
            if (frame_close) state_d = START;
         end
         START: begin
            bus.Start = 1'b1;
            state_d   = WAIT;
         end
         WAIT: begin
            if (bus.Done) state_d = DRAIN;
         end
         DRAIN: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready && out_end) state_d = ACK;
         end
         ACK: begin
            bus.Ack = 1'b1;
            if (!bus.Done) state_d = LOAD;
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         cnt_q         <= '0;
         width_q       <= '0;
         idx_q         <= '0;
         sort_cycles_q <= '0;
      end else begin
         case (state_q)
            LOAD: begin
               if (in_acc)      cnt_q   <= cnt_q + 1'b1;
               if (frame_close) width_q <= cnt_q + 1'b1;
            end
            START: sort_cycles_q <= '0;
            WAIT: begin
               sort_cycles_q <= sat_inc(sort_cycles_q);
               if (bus.Done) idx_q <= '0;
            end
            DRAIN: begin
               if (out_acc) idx_q <= idx_q + 1'b1;
            end
            ACK: begin
               if (!bus.Done) cnt_q <= '0;
            end
            default: ;
         endcase
      end
   end

   // Cleared on the way back to LOAD so slots beyond the next frame's width read as zero.
   sort_frame_buf #(.N(N_MAX), .W(DW), .IW(WW)) u_in_buf (
      .Clk     (Clk),
      .Reset   (Reset),
      .clr     (in_clr),
      .wr_en   (in_acc),
      .wr_idx  (cnt_q),
      .wr_dat  (bus.in_data),
      .ld_en   (1'b0),
      .ld_dat  ('0),
      .rd_idx  ('0),
      .rd_dat  (unused_in_rd),
      .bus_dat (bus.Ain)
   );

   sort_frame_buf #(.N(N_MAX), .W(DW), .IW(WW)) u_res_buf (
      .Clk     (Clk),
      .Reset   (Reset),
      .clr     (1'b0),
      .wr_en   (1'b0),
      .wr_idx  ('0),
      .wr_dat  ('0),
      .ld_en   (res_ld),
      .ld_dat  (bus.Aout),
      .rd_idx  (idx_q),
      .rd_dat  (res_dat),
      .bus_dat (unused_res_bus)
   );

   assign bus.width    = width_q;
   assign bus.out_data = (state_q == DRAIN) ? res_dat : '0;
   assign bus.out_last = (state_q == DRAIN) && out_end;
   assign sort_cycles  = sort_cycles_q;

endmodule
